ps_pwm_deadtime_modulator: RTL and testbench
============================================

Name: ps_pwm_deadtime_modulator

Overview:
- Consumer of the triangular carrier produced by the phase-shifted carrier generators.
- Compares the carrier count against a shadowed duty reference and produces one complementary gate pair (high side and low side) with programmable dead time.
- One instance per phase leg; all legs share one clock.
- The duty value is shadowed so that updates take effect only at carrier turning points.

Parameters:
WIDTH_TRIANG, 6, width of the carrier and duty buses.
DEAD_CYCLES, 2, dead-time length in clk cycles; legal range 1..15.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
carrier  input  WIDTH_TRIANG  triangular carrier count from a carrier generator; sweeps 0..2^W-1..0.
duty  input  WIDTH_TRIANG  duty reference; sampled only at shadow-load points.
enable  input  1  leg enable; when low, both gates are off.
pwm_h  output  1  high-side gate, registered.
pwm_l  output  1  low-side gate, registered.
period_tick  output  1  one-cycle pulse at each shadow-load point, registered.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: pwm_h=0, pwm_l=0, period_tick=0, duty_sh=0, cmp_q=0, state=OFF, dead counter=0.
- Shadow load: at every edge where carrier==0, duty_sh<=duty and period_tick<=1. At all other edges period_tick<=0.
- Compare stage: cmp_q<=(carrier < duty_sh), registered, unsigned, full width.
  - duty_sh=0: cmp is never true.
  - duty_sh=2^W-1: cmp is false only at the carrier peak.
- FSM states: OFF, LOW_ON, DEAD_LH, HIGH_ON, DEAD_HL. Outputs are flops loaded from the next-state decode:
  - pwm_h=1 only in HIGH_ON.
  - pwm_l=1 only in LOW_ON.
  - Both outputs are 0 in OFF, DEAD_LH and DEAD_HL.
- Transitions (when enable=1):
  - OFF -> DEAD_HL (counter loaded).
  - LOW_ON: if cmp_q=1 -> DEAD_LH (counter loaded).
  - HIGH_ON: if cmp_q=0 -> DEAD_HL (counter loaded).
  - DEAD_LH / DEAD_HL: the counter decrements. On expiry go to HIGH_ON if cmp_q=1, else LOW_ON.
- Decision is sampled at expiry only. A compare pulse shorter than the dead time therefore never reaches the gates; the leg returns to its previous side after DEAD_CYCLES.
- Each dead state lasts exactly DEAD_CYCLES cycles.
- Latency: a gate deasserts at the second clk edge after the carrier sample that flips the compare. The opposite gate asserts exactly DEAD_CYCLES cycles later.
- Invariant: pwm_h and pwm_l are never both 1 in any cycle, including across enable and reset events.
- enable=0 (any state): state<=OFF at the next edge, so both gates are 0 one cycle after enable falls. Shadow load and compare logic keep running.
- Re-enable: always passes through DEAD_HL for DEAD_CYCLES cycles before either gate asserts.
- Reset asserted mid-operation: both gates are 0 immediately (asynchronous). After release, behaviour is as from OFF.
- The carrier is assumed well-formed. A non-monotonic carrier affects only the compare result, never the invariant.

Optional Feature:
- Macro name: DOUBLE_UPDATE_EN.
- Defined: the shadow also loads and period_tick also pulses at each edge where carrier==2^W-1 (peak). The duty then updates twice per carrier period.
- Undefined: the shadow loads at the valley (carrier==0) only. There is no peak logic.

Test Plan:
- Reset/enable: rst_n=0 -> all outputs 0. Release with enable=1, duty=0 -> pwm_l rises at the 3rd edge (DEAD_CYCLES=2); pwm_h stays 0 forever.
- Mid duty: duty=32, 6-bit sweeping carrier -> period_tick pulses once per 126-cycle period. Each gate edge is separated from the opposite gate by exactly 2 cycles of both-off. The overlap checker never fires.
- Shadow timing: change duty 16->48 while the carrier is descending through 20 -> gate timing unchanged until carrier==0, then the new duty applies.
- Short pulse: duty=63 -> the compare is false for 1 cycle at the peak. pwm_h drops for exactly 2 cycles and then returns high; pwm_l never asserts.
- Enable drop: drive enable=0 while in HIGH_ON -> pwm_h=0 at the next edge. Re-enable -> 2 both-off cycles, then the gate is selected by the compare.
- DOUBLE_UPDATE_EN: with the macro defined, change duty while ascending -> update takes effect at carrier==63 and period_tick pulses twice per period. With the macro undefined -> update waits for the valley.

Source files
------------

// File: rtl/ps_pwm_deadtime_modulator.sv
// Complementary gate-pair modulator with a shadowed duty compare and dead-time insertion.
// Optional macro DOUBLE_UPDATE_EN: the duty shadow also reloads at the carrier peak.
module ps_pwm_deadtime_modulator #(
   parameter int WIDTH_TRIANG = 6,
   parameter int DEAD_CYCLES  = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [WIDTH_TRIANG-1:0] carrier,
   input  logic [WIDTH_TRIANG-1:0] duty,
   input  logic                    enable,
   output logic                    pwm_h,
   output logic                    pwm_l,
   output logic                    period_tick
);

   typedef enum logic [2:0] {
      OFF     = 3'd0,
      LOW_ON  = 3'd1,
      DEAD_LH = 3'd2,
      HIGH_ON = 3'd3,
      DEAD_HL = 3'd4
   } state_t;

   // The counter counts down to zero inclusive, so it is loaded one short of the length.
   localparam logic [3:0] DEAD_LOAD = 4'(DEAD_CYCLES - 1);

   state_t                  state_reg;
   state_t                  state_next;
   logic [3:0]              dead_cnt_reg;
   logic [3:0]              dead_cnt_next;
   logic [WIDTH_TRIANG-1:0] duty_sh_reg;
   logic                    cmp_reg;
   logic                    shadow_load;

`ifdef DOUBLE_UPDATE_EN
   localparam logic [WIDTH_TRIANG-1:0] CARRIER_PEAK = '1;
   assign shadow_load = (carrier == '0) || (carrier == CARRIER_PEAK);
`else
   assign shadow_load = (carrier == '0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_sh_reg <= '0;
         period_tick <= 1'b0;
         cmp_reg     <= 1'b0;
      end else begin
         if (shadow_load) begin
            duty_sh_reg <= duty;
         end
         period_tick <= shadow_load;
         cmp_reg     <= (carrier < duty_sh_reg);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= OFF;
         dead_cnt_reg <= '0;
         pwm_h        <= 1'b0;
         pwm_l        <= 1'b0;
      end else begin
         state_reg    <= state_next;
         dead_cnt_reg <= dead_cnt_next;
         pwm_h        <= (state_next == HIGH_ON);
         pwm_l        <= (state_next == LOW_ON);
      end
   end

   // The side decision is taken only when a dead interval expires, which swallows short compare pulses.
   always_comb begin
      state_next    = state_reg;
      dead_cnt_next = dead_cnt_reg;
      if (!enable) begin
         state_next    = OFF;
         dead_cnt_next = '0;
      end else begin
         case (state_reg)
            OFF: begin
               state_next    = DEAD_HL;
               dead_cnt_next = DEAD_LOAD;
            end
            LOW_ON: begin
               if (cmp_reg) begin
                  state_next    = DEAD_LH;
                  dead_cnt_next = DEAD_LOAD;
               end
            end
            HIGH_ON: begin
               if (!cmp_reg) begin
                  state_next    = DEAD_HL;
                  dead_cnt_next = DEAD_LOAD;
               end
            end
            DEAD_LH, DEAD_HL: begin
               if (dead_cnt_reg == '0) begin
                  state_next = cmp_reg ? HIGH_ON : LOW_ON;
               end else begin
                  dead_cnt_next = dead_cnt_reg - 4'd1;
               end
            end
            default: begin
               state_next    = OFF;
               dead_cnt_next = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps_pwm_deadtime_modulator.sv
// Scoreboard bench for ps_pwm_deadtime_modulator: stimulus pushes expected gate/tick values,
// a negedge monitor pops and compares; directed window counts are hand-derived.
module tb_ps_pwm_deadtime_modulator;

   localparam int W    = 6;
   localparam int DEAD = 2;
`ifdef DOUBLE_UPDATE_EN
   localparam int TICKS = 2;
`else
   localparam int TICKS = 1;
`endif

   logic         clk;
   logic         rst_n;
   logic [W-1:0] carrier;
   logic [W-1:0] duty;
   logic         enable;
   logic         pwm_h;
   logic         pwm_l;
   logic         period_tick;

   ps_pwm_deadtime_modulator #(.WIDTH_TRIANG(W), .DEAD_CYCLES(DEAD)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .carrier     (carrier),
      .duty        (duty),
      .enable      (enable),
      .pwm_h       (pwm_h),
      .pwm_l       (pwm_l),
      .period_tick (period_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int   cyc;
      logic h;
      logic l;
      logic t;
   } exp_t;

   exp_t q[$];
   int   cyc_cnt = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   overlap_cnt = 0;
   int   h_cnt = 0;
   int   l_cnt = 0;
   int   tick_cnt = 0;

   // reference: m_on 0 = none, 1 = low side, 2 = high side; m_dead = remaining dead cycles
   logic [W-1:0] m_sh = '0;
   logic         m_cmp = 1'b0;
   logic         m_tick = 1'b0;
   logic         m_off = 1'b1;
   int           m_on = 0;
   int           m_dead = 0;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   always @(negedge clk) begin
      if (pwm_h && pwm_l) overlap_cnt++;
      if (q.size() > 0 && q[0].cyc == cyc_cnt) begin
         exp_t e;
         e = q.pop_front();
         n_checks += 3;
         if (pwm_h !== e.h) begin
            n_errors++;
            $display("FAIL pwm_h cyc=%0d got=%b want=%b", cyc_cnt, pwm_h, e.h);
         end
         if (pwm_l !== e.l) begin
            n_errors++;
            $display("FAIL pwm_l cyc=%0d got=%b want=%b", cyc_cnt, pwm_l, e.l);
         end
         if (period_tick !== e.t) begin
            n_errors++;
            $display("FAIL period_tick cyc=%0d got=%b want=%b", cyc_cnt, period_tick, e.t);
         end
      end
   end

   task automatic check(input string name, input int act, input int want);
      n_checks++;
      if (act != want) begin
         n_errors++;
         $display("FAIL %s got=%0d want=%0d", name, act, want);
      end else begin
         $display("check %s = %0d ok", name, act);
      end
   endtask

   task automatic model_edge();
      logic cmp_old;
      logic load;
      if (!rst_n) begin
         m_sh = '0; m_cmp = 1'b0; m_tick = 1'b0; m_off = 1'b1; m_on = 0; m_dead = 0;
      end else begin
         cmp_old = m_cmp;
         if (!enable) begin
            m_off = 1'b1; m_on = 0; m_dead = 0;
         end else if (m_off) begin
            m_off = 1'b0; m_on = 0; m_dead = DEAD;
         end else if (m_dead > 0) begin
            m_dead--;
            if (m_dead == 0) m_on = cmp_old ? 2 : 1;
         end else if (m_on == 1 && cmp_old) begin
            m_on = 0; m_dead = DEAD;
         end else if (m_on == 2 && !cmp_old) begin
            m_on = 0; m_dead = DEAD;
         end
         m_cmp = (carrier < m_sh);
`ifdef DOUBLE_UPDATE_EN
         load = (carrier == 6'd0) || (carrier == 6'd63);
`else
         load = (carrier == 6'd0);
`endif
         m_tick = load;
         if (load) m_sh = duty;
      end
   endtask

   task automatic step(input logic [W-1:0] c, input logic [W-1:0] d, input logic e, input logic r);
      exp_t x;
      @(posedge clk);
      #1;
      if (pwm_h) h_cnt++;
      if (pwm_l) l_cnt++;
      if (period_tick) tick_cnt++;
      if (!r && rst_n && q.size() > 0 && q[q.size()-1].cyc == cyc_cnt) begin
         x = q.pop_back();
         x.h = 1'b0; x.l = 1'b0; x.t = 1'b0;
         q.push_back(x);
      end
      carrier = c;
      duty    = d;
      enable  = e;
      rst_n   = r;
      model_edge();
      x.cyc = cyc_cnt + 1;
      x.h   = (m_on == 2);
      x.l   = (m_on == 1);
      x.t   = m_tick;
      q.push_back(x);
   endtask

   function automatic logic [W-1:0] tri_val(input int k);
      int v;
      v = (k < 64) ? k : 126 - k;
      return v[W-1:0];
   endfunction

   task automatic run_period(input logic [W-1:0] d);
      for (int k = 0; k < 126; k++) step(tri_val(k), d, 1'b1, 1'b1);
   endtask

   task automatic clear_stats();
      h_cnt = 0; l_cnt = 0; tick_cnt = 0;
   endtask

   initial begin
      int first_l;
      carrier = '0; duty = '0; enable = 1'b1; rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("reset_pwm_h", int'(pwm_h), 0);
      check("reset_pwm_l", int'(pwm_l), 0);
      check("reset_tick", int'(period_tick), 0);
      repeat (3) step(6'd0, 6'd0, 1'b1, 1'b0);

      // release with duty 0: low side after the 3rd edge, high side never
      clear_stats();
      first_l = -1;
      for (int k = 0; k < 126; k++) begin
         step(tri_val(k), 6'd0, 1'b1, 1'b1);
         if (pwm_l && first_l < 0) first_l = k;
      end
      check("release_first_l_edge", first_l, 3);
      check("duty0_h_cycles", h_cnt, 0);

      // duty 32: 63 compare-true samples per period, each side loses DEAD cycles
      run_period(6'd32);
      clear_stats();
      run_period(6'd32);
      check("duty32_h_cycles", h_cnt, 61);
      check("duty32_l_cycles", l_cnt, 61);
      check("duty32_ticks", tick_cnt, TICKS);

      // duty 16 -> 48 written while descending through carrier 20: no effect until the valley
      run_period(6'd16);
      clear_stats();
      for (int k = 0; k < 126; k++) step(tri_val(k), (k >= 106) ? 6'd48 : 6'd16, 1'b1, 1'b1);
      check("shadow_old_h_cycles", h_cnt, 29);
      check("shadow_old_l_cycles", l_cnt, 93);
      clear_stats();
      run_period(6'd48);
      check("shadow_new_h_cycles", h_cnt, 93);
      check("shadow_new_l_cycles", l_cnt, 29);

      // 16 -> 48 written while ascending: valley-only build keeps the old duty for the period
      run_period(6'd16);
      clear_stats();
      for (int k = 0; k < 126; k++) step(tri_val(k), (k >= 10) ? 6'd48 : 6'd16, 1'b1, 1'b1);
`ifndef DOUBLE_UPDATE_EN
      check("ascend_update_h_cycles", h_cnt, 29);
`endif
      check("ascend_update_ticks", tick_cnt, TICKS);

      // duty 63: one-sample compare drop at the peak only blanks the high side for DEAD cycles
      run_period(6'd63);
      clear_stats();
      run_period(6'd63);
      check("short_pulse_h_cycles", h_cnt, 124);
      check("short_pulse_l_cycles", l_cnt, 0);

      // enable drop in HIGH_ON, then re-enable through DEAD_HL
      for (int k = 0; k < 126; k++) begin
         step(tri_val(k), 6'd63, !(k >= 10 && k < 20), 1'b1);
         if (k == 10) check("en_before_drop_h", int'(pwm_h), 1);
         if (k == 11) check("en_drop_h", int'(pwm_h), 0);
         if (k == 22) check("reen_dead_h", int'(pwm_h | pwm_l), 0);
         if (k == 23) check("reen_h", int'(pwm_h), 1);
      end

      // async reset mid-period; shadow cleared so the leg restarts on the low side
      for (int k = 0; k < 126; k++) begin
         step(tri_val(k), 6'd63, 1'b1, !(k >= 30 && k < 33));
         if (k == 30) begin
            #1;
            check("async_reset_h", int'(pwm_h), 0);
         end
         if (k == 36) begin
            check("post_reset_l", int'(pwm_l), 1);
            check("post_reset_h", int'(pwm_h), 0);
         end
      end
      run_period(6'd63);

      repeat (3) @(negedge clk);
      #1;
      check("scoreboard_drained", q.size(), 0);
      check("overlap_cycles", overlap_cnt, 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
